// File: rtl/special_queue_pkg.sv
// Shared encodings and helpers for the special queue and its access arbiter.
// The queue and this arbiter both use the 2-bit operation flag {pop, push}.
package special_queue_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_BOTH = 2'b11;

  // Next round-robin pointer after a grant to index ptr among n ports (n <= 8).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n);
    if (int'(ptr) >= n - 1) return 3'd0;
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The pointer moves one past the granted index, and holds when there is no grant.
module rr_arbiter
  import special_queue_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW-1:0] ptr;

  // Scan from the pointer upward, wrapping. The first requester found wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    if (en && rst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!any_gnt && req[IW'(idx)]) begin
          any_gnt           = 1'b1;
          gnt[IW'(idx)]     = 1'b1;
          gnt_idx           = IW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= IW'(rr_next(3'(gnt_idx), N));
    end
  end

endmodule

// File: rtl/queue_access_arbiter.sv
// Arbitrates NUM_PROD producers and NUM_CONS consumers onto one special queue,
// returns popped words to their consumer, and keeps a shadow occupancy count.
module queue_access_arbiter
  import special_queue_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int NUM_CONS = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  localparam int PW = $clog2(NUM_PROD),
  localparam int CW = $clog2(NUM_CONS),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PROD-1:0]        prod_req,
  input  logic [NUM_PROD*DATA_W-1:0] prod_data,
  output logic [NUM_PROD-1:0]        prod_gnt,
  input  logic [NUM_CONS-1:0]        cons_req,
  output logic [NUM_CONS-1:0]        cons_gnt,
  output logic                       cons_valid,
  output logic [CW-1:0]              cons_id,
  output logic [DATA_W-1:0]          cons_data,
  output logic                       q_push,
  output logic                       q_pop,
  output logic [DATA_W-1:0]          q_wdata,
  output logic [1:0]                 q_op,
  input  logic [DATA_W-1:0]          q_rdata,
  input  logic                       q_full,
  input  logic                       q_empty,
  output logic [LW-1:0]              level
);

  // Handshake: req is level-held until gnt. A gnt means the transfer happens
  // in that same cycle. Dropping req before gnt withdraws the request.

  logic          pop_ok;
  logic          push_ok;
  logic [PW-1:0] prod_idx;
  logic [CW-1:0] cons_idx;
  logic          rd_valid;
  logic [CW-1:0] rd_id;
  logic [LW-1:0] lvl;
  logic          sat_up;
  logic          sat_dn;

  // The consumer side is resolved first because q_pop feeds push_ok.
  assign pop_ok = !q_empty;

  rr_arbiter #(.N(NUM_CONS)) u_cons_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (cons_req),
    .en      (pop_ok),
    .gnt     (cons_gnt),
    .gnt_idx (cons_idx),
    .any_gnt (q_pop)
  );

  assign push_ok = !q_full || q_pop;

  rr_arbiter #(.N(NUM_PROD)) u_prod_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (prod_req),
    .en      (push_ok),
    .gnt     (prod_gnt),
    .gnt_idx (prod_idx),
    .any_gnt (q_push)
  );

  assign q_wdata = prod_data[prod_idx*DATA_W +: DATA_W];

  always_comb begin
    q_op = OP_IDLE;
    if (q_pop && q_push) q_op = OP_BOTH;
    else if (q_pop)      q_op = OP_POP;
    else if (q_push)     q_op = OP_PUSH;
  end

  // Return path: the queue presents read data one cycle after the pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= q_pop;
      if (q_pop) rd_id <= cons_idx;
    end
  end

  assign sat_up = q_push && !q_pop && (lvl == LW'(DEPTH));
  assign sat_dn = q_pop && !q_push && (lvl == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl <= '0;
    end else begin
      level_mismatch: assert (!(sat_up || sat_dn));
      if (q_push && !q_pop && !sat_up)      lvl <= lvl + LW'(1);
      else if (q_pop && !q_push && !sat_dn) lvl <= lvl - LW'(1);
    end
  end

  // Registered outputs read as zero for the whole time reset is held.
  assign cons_valid = rd_valid && rst_n;
  assign cons_id    = rst_n ? rd_id : '0;
  assign cons_data  = q_rdata;
  assign level      = rst_n ? lvl : '0;

endmodule
